// File: rtl/dds_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dds_sweep_ctrl
// Purpose  : Stepped frequency-sweep sequencer feeding DDS frequency words
//            over valid/ready, with per-point dwell and per-sweep wave select.
// Revision : 1.0 - initial release
// ============================================================================
module dds_sweep_ctrl #(
    parameter int FW_W    = 32,
    parameter int DWELL_W = 24,
    parameter int WAVE_W  = 4
) (
    input  logic               sys_clk,
    input  logic               sys_rst,
    input  logic               start,
    input  logic               stop,
    input  logic [1:0]         mode,
    input  logic [FW_W-1:0]    f_start,
    input  logic [FW_W-1:0]    f_stop,
    input  logic [FW_W-1:0]    f_step,
    input  logic [DWELL_W-1:0] dwell,
    input  logic [WAVE_W-1:0]  wave_sel_in,
    input  logic               cfg_ready,
    output logic               cfg_valid,
    output logic [FW_W-1:0]    freq_word,
    output logic [WAVE_W-1:0]  wave_select,
    output logic               busy,
    output logic               done
);

    localparam logic [2:0] c_S_IDLE  = 3'd0;
    localparam logic [2:0] c_S_LOAD  = 3'd1;
    localparam logic [2:0] c_S_PUSH  = 3'd2;
    localparam logic [2:0] c_S_DWELL = 3'd3;
    localparam logic [2:0] c_S_STEP  = 3'd4;

    localparam logic [1:0] c_M_UP   = 2'b00;
    localparam logic [1:0] c_M_DOWN = 2'b01;
    localparam logic [1:0] c_M_WRAP = 2'b10;
    localparam logic [1:0] c_M_TRI  = 2'b11;

    localparam logic [DWELL_W-1:0] c_CNT_ONE = {{(DWELL_W-1){1'b0}}, 1'b1};

    logic [2:0]         r_state, w_state_nxt;
    logic [1:0]         r_mode;
    logic [FW_W-1:0]    r_f_start, r_f_stop, r_f_step;
    logic [FW_W-1:0]    r_cur, w_cur_nxt;
    logic [DWELL_W-1:0] r_dwell, r_cnt, w_cnt_nxt;
    logic [WAVE_W-1:0]  r_wave_lat, r_wave_select;
    logic               r_dir_up, w_dir_up_nxt;
    logic               r_stop_pend, w_stop_pend_nxt;
    logic               r_cfg_valid, r_busy, r_done;
    logic               w_cfg_valid_nxt, w_busy_nxt, w_done_nxt;
    logic               w_going_up;
    logic [FW_W:0]      w_sum, w_lo_lim;

    // One extra bit so limit comparisons never wrap at the top of the range.
    assign w_sum      = {1'b0, r_cur} + {1'b0, r_f_step};
    assign w_lo_lim   = {1'b0, r_f_start} + {1'b0, r_f_step};
    assign w_going_up = (r_mode == c_M_TRI) ? r_dir_up : (r_mode != c_M_DOWN);

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) r_state <= c_S_IDLE;
        else         r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt     = r_state;
        w_cur_nxt       = r_cur;
        w_dir_up_nxt    = r_dir_up;
        w_cnt_nxt       = r_cnt;
        w_stop_pend_nxt = r_stop_pend;
        case (r_state)
            c_S_IDLE: begin
                w_stop_pend_nxt = 1'b0;
                if (start && !stop) w_state_nxt = c_S_LOAD;
            end
            c_S_LOAD: begin
                if (stop || (r_f_start > r_f_stop)) begin
                    w_state_nxt = c_S_IDLE;
                end else begin
                    w_cur_nxt    = (r_mode == c_M_DOWN) ? r_f_stop : r_f_start;
                    w_dir_up_nxt = 1'b1;
                    w_state_nxt  = c_S_PUSH;
                end
            end
            c_S_PUSH: begin
                // A stop seen while waiting is remembered; valid is never withdrawn.
                if (stop) w_stop_pend_nxt = 1'b1;
                if (cfg_ready) begin
                    if (stop || r_stop_pend) begin
                        w_state_nxt = c_S_IDLE;
                    end else begin
                        w_cnt_nxt   = (r_dwell == '0) ? c_CNT_ONE : r_dwell;
                        w_state_nxt = c_S_DWELL;
                    end
                end
            end
            c_S_DWELL: begin
                if (stop)                    w_state_nxt = c_S_IDLE;
                else if (r_cnt <= c_CNT_ONE) w_state_nxt = c_S_STEP;
                else                         w_cnt_nxt   = r_cnt - c_CNT_ONE;
            end
            c_S_STEP: begin
                w_state_nxt = c_S_PUSH;
                if (stop || (r_f_step == '0)) begin
                    w_state_nxt = c_S_IDLE;
                end else if (w_going_up) begin
                    if (w_sum > {1'b0, r_f_stop}) begin
                        case (r_mode)
                            c_M_WRAP: w_cur_nxt = r_f_start;
                            c_M_TRI: begin
                                w_dir_up_nxt = 1'b0;
                                w_cur_nxt    = ({1'b0, r_cur} < w_lo_lim) ? r_f_start
                                                                          : r_cur - r_f_step;
                            end
                            default:  w_state_nxt = c_S_IDLE;
                        endcase
                    end else begin
                        w_cur_nxt = w_sum[FW_W-1:0];
                    end
                end else if ({1'b0, r_cur} < w_lo_lim) begin
                    if (r_mode == c_M_TRI) begin
                        w_dir_up_nxt = 1'b1;
                        w_cur_nxt    = (w_sum > {1'b0, r_f_stop}) ? r_f_stop : w_sum[FW_W-1:0];
                    end else begin
                        w_state_nxt = c_S_IDLE;
                    end
                end else begin
                    w_cur_nxt = r_cur - r_f_step;
                end
            end
            default: w_state_nxt = c_S_IDLE;
        endcase
    end

    always_comb begin
        w_busy_nxt      = (w_state_nxt != c_S_IDLE);
        w_cfg_valid_nxt = (w_state_nxt == c_S_PUSH);
        w_done_nxt      = (r_state != c_S_IDLE) && (w_state_nxt == c_S_IDLE);
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_mode        <= '0;
            r_f_start     <= '0;
            r_f_stop      <= '0;
            r_f_step      <= '0;
            r_dwell       <= '0;
            r_wave_lat    <= '0;
            r_wave_select <= '0;
            r_cur         <= '0;
            r_dir_up      <= 1'b1;
            r_cnt         <= '0;
            r_stop_pend   <= 1'b0;
            r_cfg_valid   <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
        end else begin
            if ((r_state == c_S_IDLE) && start && !stop) begin
                r_mode     <= mode;
                r_f_start  <= f_start;
                r_f_stop   <= f_stop;
                r_f_step   <= f_step;
                r_dwell    <= dwell;
                r_wave_lat <= wave_sel_in;
            end
            if (r_state == c_S_LOAD) r_wave_select <= r_wave_lat;
            r_cur       <= w_cur_nxt;
            r_dir_up    <= w_dir_up_nxt;
            r_cnt       <= w_cnt_nxt;
            r_stop_pend <= w_stop_pend_nxt;
            r_cfg_valid <= w_cfg_valid_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
        end
    end

    assign cfg_valid   = r_cfg_valid;
    assign freq_word   = r_cur;
    assign wave_select = r_wave_select;
    assign busy        = r_busy;
    assign done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_dds_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dds_sweep_ctrl
// Purpose  : Self-checking bench for dds_sweep_ctrl (vector table + scoreboard).
// Revision : 1.0 - initial release
// ============================================================================
module tb_dds_sweep_ctrl;

    localparam int FW_W    = 32;
    localparam int DWELL_W = 24;
    localparam int WAVE_W  = 4;

    logic               sys_clk = 1'b0;
    logic               sys_rst = 1'b1;
    logic               start = 1'b0, stop = 1'b0, cfg_ready = 1'b0;
    logic [1:0]         mode = '0;
    logic [FW_W-1:0]    f_start = '0, f_stop = '0, f_step = '0;
    logic [DWELL_W-1:0] dwell = '0;
    logic [WAVE_W-1:0]  wave_sel_in = '0;
    logic               cfg_valid, busy, done;
    logic [FW_W-1:0]    freq_word;
    logic [WAVE_W-1:0]  wave_select;

    dds_sweep_ctrl #(.FW_W(FW_W), .DWELL_W(DWELL_W), .WAVE_W(WAVE_W)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst), .start(start), .stop(stop),
        .mode(mode), .f_start(f_start), .f_stop(f_stop), .f_step(f_step),
        .dwell(dwell), .wave_sel_in(wave_sel_in), .cfg_ready(cfg_ready),
        .cfg_valid(cfg_valid), .freq_word(freq_word), .wave_select(wave_select),
        .busy(busy), .done(done)
    );

    always #5 sys_clk = ~sys_clk;

    typedef struct {
        logic [1:0]            md;
        logic [31:0]           fs, fe, st;
        logic [23:0]           dw;
        logic [3:0]            wv;
        int                    n;
        logic [3:0][31:0]      w;
    } vec_t;

    int          n_total = 0, n_pass = 0;
    int          cyc = 0, hs_count = 0, last_hs = -1, exp_gap = 0;
    logic [31:0] sb_q [$];

    always @(posedge sys_clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic fail_now(input string name);
        n_total++;
        $display("FAIL %s: got timeout expected event", name);
    endtask

    // Scoreboard: every accepted word must match the next expected one.
    always @(negedge sys_clk) begin
        if (cfg_valid && cfg_ready) begin
            if (sb_q.size() == 0) begin
                check("unexpected_word", {32'd0, freq_word}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                check("freq_word", freq_word, sb_q.pop_front());
            end
            if (exp_gap != 0 && last_hs >= 0) check("word_gap", cyc - last_hs, exp_gap);
            last_hs = cyc;
            hs_count++;
        end
    end

    function automatic vec_t mk(input logic [1:0] md, input logic [31:0] fs, fe, st,
                                input logic [23:0] dw, input logic [3:0] wv, input int n,
                                input logic [31:0] a, b, c, d);
        vec_t v;
        v.md = md; v.fs = fs; v.fe = fe; v.st = st; v.dw = dw; v.wv = wv; v.n = n;
        v.w[0] = a; v.w[1] = b; v.w[2] = c; v.w[3] = d;
        return v;
    endfunction

    task automatic pulse_start(input logic [1:0] md, input logic [31:0] fs, fe, st,
                               input logic [23:0] dw, input logic [3:0] wv, output int k);
        @(posedge sys_clk); #1;
        mode = md; f_start = fs; f_stop = fe; f_step = st; dwell = dw; wave_sel_in = wv;
        start = 1'b1;
        @(posedge sys_clk); #1;
        start = 1'b0;
        k = cyc;
        // Scramble inputs mid-sweep: the latched copy must be used.
        mode = 2'($urandom); f_start = $urandom; f_stop = $urandom; f_step = $urandom;
        dwell = 24'($urandom); wave_sel_in = 4'($urandom);
    endtask

    task automatic run_vec(input vec_t v);
        int k, d;
        bit got;
        d = (v.dw == 0) ? 1 : int'(v.dw);
        for (int i = 0; i < v.n; i++) sb_q.push_back(v.w[i]);
        exp_gap = d + 2; last_hs = -1;
        cfg_ready = 1'b1;
        pulse_start(v.md, v.fs, v.fe, v.st, v.dw, v.wv, k);
        @(negedge sys_clk);
        check("busy_in_load", busy, 1);
        check("valid_in_load", cfg_valid, 0);
        got = 0;
        for (int t = 0; t < 300 && !got; t++) begin
            @(negedge sys_clk);
            if (t == 0) check("wave_select", wave_select, v.wv);
            if (done) begin
                got = 1;
                check("done_latency", cyc - k, 1 + v.n * (d + 2));
                check("busy_at_done", busy, 0);
            end
        end
        if (!got) fail_now("done_timeout");
        check("words_left", sb_q.size(), 0);
        sb_q.delete();
    endtask

    vec_t vecs [8];

    initial begin
        int k, base;
        bit got, seen_done;
        vec_t pv;

        vecs[0] = mk(2'b00, 100, 130, 10, 4, 3, 4, 100, 110, 120, 130);
        vecs[1] = mk(2'b01, 100, 130, 12, 4, 5, 3, 130, 118, 106, 0);
        vecs[2] = mk(2'b00, 50, 40, 10, 4, 6, 0, 0, 0, 0, 0);
        vecs[3] = mk(2'b10, 50, 50, 0, 2, 7, 1, 50, 0, 0, 0);
        vecs[4] = mk(2'b00, 0, 5, 2, 0, 8, 3, 0, 2, 4, 0);
        vecs[5] = mk(2'b01, 7, 7, 3, 1, 9, 1, 7, 0, 0, 0);
        vecs[6] = mk(2'b00, 32'hFFFF_FFF0, 32'hFFFF_FFFF, 8, 1, 10, 2,
                     32'hFFFF_FFF0, 32'hFFFF_FFF8, 0, 0);
        vecs[7] = mk(2'b01, 0, 20, 8, 3, 11, 3, 20, 12, 4, 0);

        #1;
        check("rst_cfg_valid", cfg_valid, 0);
        check("rst_freq_word", freq_word, 0);
        check("rst_wave_select", wave_select, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        repeat (3) @(posedge sys_clk);
        #1 sys_rst = 1'b0;

        foreach (vecs[i]) run_vec(vecs[i]);

        // start together with stop in IDLE is ignored
        @(posedge sys_clk); #1;
        start = 1'b1; stop = 1'b1;
        @(posedge sys_clk); #1;
        start = 1'b0; stop = 1'b0;
        repeat (3) begin
            @(negedge sys_clk);
            check("start_stop_busy", busy, 0);
        end

        // Triangle sweep, stop during dwell
        cfg_ready = 1'b1; exp_gap = 5; last_hs = -1;
        foreach (vecs[i]) if (i < 7) sb_q.push_back(32'(i == 0 ? 0 : (i == 1 || i == 3 || i == 5) ? 10 : (i == 4 ? 0 : 20)));
        base = hs_count;
        pulse_start(2'b11, 0, 20, 10, 3, 4'hA, k);
        got = 0;
        for (int t = 0; t < 200 && !got; t++) begin
            @(negedge sys_clk); #1;
            if (hs_count >= base + 7) got = 1;
        end
        if (!got) fail_now("tri_timeout");
        @(posedge sys_clk); #1 stop = 1'b1;
        @(posedge sys_clk); #1 stop = 1'b0;
        @(negedge sys_clk);
        check("tri_stop_done", done, 1);
        check("tri_stop_busy", busy, 0);
        check("tri_words_left", sb_q.size(), 0);
        sb_q.delete();

        // Back-pressure with stop during PUSH
        cfg_ready = 1'b0; exp_gap = 0;
        sb_q.push_back(0);
        pulse_start(2'b10, 0, 100, 10, 1, 4'h2, k);
        @(negedge sys_clk);
        @(negedge sys_clk);
        check("bp_valid_up", cfg_valid, 1);
        @(posedge sys_clk); #1 stop = 1'b1;
        @(posedge sys_clk); #1 stop = 1'b0;
        for (int t = 0; t < 5; t++) begin
            @(negedge sys_clk);
            check("bp_valid_hold", cfg_valid, 1);
            check("bp_word_hold", freq_word, 0);
            if (t == 0) begin
                @(posedge sys_clk); #1;
            end
        end
        @(posedge sys_clk); #1 cfg_ready = 1'b1;
        @(negedge sys_clk);
        @(posedge sys_clk); #1 cfg_ready = 1'b0;
        @(negedge sys_clk);
        check("bp_done", done, 1);
        check("bp_busy", busy, 0);
        check("bp_valid_drop", cfg_valid, 0);
        check("bp_words_left", sb_q.size(), 0);
        sb_q.delete();

        // Asynchronous reset during a continuous sweep
        cfg_ready = 1'b1; exp_gap = 7; last_hs = -1;
        sb_q.push_back(0); sb_q.push_back(10);
        base = hs_count;
        pulse_start(2'b10, 0, 30, 10, 5, 4'h9, k);
        got = 0;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge sys_clk); #1;
            if (hs_count >= base + 2) got = 1;
        end
        if (!got) fail_now("rst_sweep_timeout");
        @(posedge sys_clk); #2 sys_rst = 1'b1;
        #1;
        check("arst_cfg_valid", cfg_valid, 0);
        check("arst_freq_word", freq_word, 0);
        check("arst_wave_select", wave_select, 0);
        check("arst_busy", busy, 0);
        check("arst_done", done, 0);
        sb_q.delete();
        seen_done = 0;
        repeat (3) begin
            @(negedge sys_clk);
            if (done) seen_done = 1;
        end
        @(posedge sys_clk); #1 sys_rst = 1'b0;
        repeat (2) begin
            @(negedge sys_clk);
            if (done) seen_done = 1;
        end
        check("arst_no_done", seen_done, 0);

        pv = vecs[0];
        pv.wv = 4'hC;
        run_vec(pv);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
